// File: rtl/rounding_div_arbiter.sv
// Round-robin arbiter in front of one shared rounding divide-by-2^DIV_LOG2 stage.
// The result register is a single entry; its id tells the consumer which requester issued it.
module rounding_div_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DIV_LOG2  = 3,
  parameter int OUT_WIDTH = 32,
  parameter int IN_WIDTH  = OUT_WIDTH + DIV_LOG2,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*IN_WIDTH-1:0] req_din,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [OUT_WIDTH-1:0]        rsp_dout,
  output logic [ID_W-1:0]             rsp_id,
  output logic                        rsp_sat
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready is one-hot and never depends on req_din; rsp_valid is the FULL state itself.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       last_q, last_d;
  logic [OUT_WIDTH-1:0]  dout_q, dout_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic                  sat_q, sat_d;

  logic                  can_accept;
  logic                  grant_found;
  logic [ID_W-1:0]       grant_idx;
  logic [IN_WIDTH-1:0]   din_sel;
  logic                  accept;
  logic [OUT_WIDTH:0]    t_sum;
  int                    idx;

  assign can_accept = (state_q == EMPTY) || rsp_ready;

  // Search starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    din_sel     = '0;
    idx         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
        din_sel     = req_din[idx*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  // rst_n gates the grant so no requester sees ready while reset is held.
  assign accept = can_accept && grant_found && rst_n;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  // Ties round up: the bit just below the quotient is the half-LSB.
  assign t_sum = {1'b0, din_sel[IN_WIDTH-1:DIV_LOG2]} + (OUT_WIDTH+1)'(din_sel[DIV_LOG2-1]);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    dout_d  = dout_q;
    id_d    = id_q;
    sat_d   = sat_q;
    if (can_accept) begin
      state_d = grant_found ? FULL : EMPTY;
    end
    if (accept) begin
      last_d = grant_idx;
      id_d   = grant_idx;
      sat_d  = t_sum[OUT_WIDTH];
      dout_d = t_sum[OUT_WIDTH] ? {OUT_WIDTH{1'b1}} : t_sum[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      last_q  <= ID_W'(NUM_REQ-1);
      dout_q  <= '0;
      id_q    <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
      id_q    <= id_d;
      sat_q   <= sat_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_dout  = dout_q;
  assign rsp_id    = id_q;
  assign rsp_sat   = sat_q;

endmodule

// File: tb/tb_rounding_div_arbiter.sv
// Directed bench for rounding_div_arbiter: a default instance plus a narrow
// OUT_WIDTH=2 instance for saturation cases.
module tb_rounding_div_arbiter;

  localparam int NR  = 4;
  localparam int DL  = 3;
  localparam int OW  = 32;
  localparam int IW  = OW + DL;
  localparam int OW1 = 2;
  localparam int IW1 = OW1 + DL;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*IW-1:0]  req_din;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [OW-1:0]     rsp_dout;
  logic [1:0]        rsp_id;
  logic              rsp_sat;

  logic [NR-1:0]     req_valid1;
  logic [NR-1:0]     req_ready1;
  logic [NR*IW1-1:0] req_din1;
  logic              rsp_valid1;
  logic              rsp_ready1;
  logic [OW1-1:0]    rsp_dout1;
  logic [1:0]        rsp_id1;
  logic              rsp_sat1;

  int checks   = 0;
  int failures = 0;

  rounding_div_arbiter #(.NUM_REQ(NR), .DIV_LOG2(DL), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_din(req_din), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dout(rsp_dout), .rsp_id(rsp_id), .rsp_sat(rsp_sat)
  );

  rounding_div_arbiter #(.NUM_REQ(NR), .DIV_LOG2(DL), .OUT_WIDTH(OW1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_din(req_din1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_dout(rsp_dout1), .rsp_id(rsp_id1), .rsp_sat(rsp_sat1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input int i, input logic [IW-1:0] v);
    req_din[i*IW +: IW] = v;
  endtask

  task automatic set_din1(input int i, input logic [IW1-1:0] v);
    req_din1[i*IW1 +: IW1] = v;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected-value tables, hand computed for DIV_LOG2=3
  logic [IW-1:0]  rnd_din [4] = '{35'd19, 35'd36, 35'd7, 35'd3};
  logic [OW-1:0]  rnd_exp [4] = '{32'd2, 32'd5, 32'd1, 32'd0};
  logic [IW1-1:0] sat_din [3] = '{5'd28, 5'd31, 5'd27};
  logic [OW1-1:0] sat_exp [3] = '{2'd3, 2'd3, 2'd3};
  logic           sat_flg [3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_din    = '0;
    rsp_ready  = 1'b1;
    req_valid1 = '0;
    req_din1   = '0;
    rsp_ready1 = 1'b1;

    // Reset state, with all requesters valid: no grant may be given
    req_valid = 4'b1111;
    tick();
    tick();
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_dout",  64'(rsp_dout),  64'd0);
    check("rst_id",    64'(rsp_id),    64'd0);
    check("rst_sat",   64'(rsp_sat),   64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    rst_n = 1'b1;
    tick();
    check("idle_valid", 64'(rsp_valid), 64'd0);

    // 1: single req0, din=20 -> 3
    set_din(0, 35'd20);
    req_valid = 4'b0001;
    #1;
    check("t1_ready", 64'(req_ready), 64'b0001);
    check("t1_pre_valid", 64'(rsp_valid), 64'd0);
    tick();
    req_valid = '0;
    check("t1_valid", 64'(rsp_valid), 64'd1);
    check("t1_dout",  64'(rsp_dout),  64'd3);
    check("t1_id",    64'(rsp_id),    64'd0);
    check("t1_sat",   64'(rsp_sat),   64'd0);
    tick();
    check("t1_drain", 64'(rsp_valid), 64'd0);

    // 2: rounding, requester k issues vector k (leaves pointer at 3)
    for (int k = 0; k < 4; k++) begin
      set_din(k, rnd_din[k]);
      req_valid = 4'b0001 << k;
      tick();
      req_valid = '0;
      check($sformatf("t2_dout_%0d", k), 64'(rsp_dout), 64'(rnd_exp[k]));
      check($sformatf("t2_id_%0d", k),   64'(rsp_id),   64'(k));
      check($sformatf("t2_sat_%0d", k),  64'(rsp_sat),  64'd0);
      tick();
    end

    // 3: saturation on the OUT_WIDTH=2 instance
    for (int k = 0; k < 3; k++) begin
      set_din1(0, sat_din[k]);
      req_valid1 = 4'b0001;
      tick();
      req_valid1 = '0;
      check($sformatf("t3_valid_%0d", k), 64'(rsp_valid1), 64'd1);
      check($sformatf("t3_dout_%0d", k),  64'(rsp_dout1),  64'(sat_exp[k]));
      check($sformatf("t3_sat_%0d", k),   64'(rsp_sat1),   64'(sat_flg[k]));
      tick();
    end

    // 4: all valid, rsp_ready=1, grants rotate 0,1,2,3,0,1,2,3
    for (int i = 0; i < NR; i++) set_din(i, IW'(8 * (10 + i)));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("t4_grant_%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      check($sformatf("t4_valid_%0d", k), 64'(rsp_valid), 64'd1);
      check($sformatf("t4_id_%0d", k),    64'(rsp_id),    64'(k % 4));
      check($sformatf("t4_dout_%0d", k),  64'(rsp_dout),  64'(10 + (k % 4)));
    end
    req_valid = '0;
    tick();
    check("t4_drain", 64'(rsp_valid), 64'd0);

    // 5: stall for 5 clocks while FULL
    set_din(0, 35'd80);
    set_din(1, 35'd88);
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t5_ready_%0d", k), 64'(req_ready), 64'd0);
      check($sformatf("t5_valid_%0d", k), 64'(rsp_valid), 64'd1);
      check($sformatf("t5_id_%0d", k),    64'(rsp_id),    64'd0);
      check($sformatf("t5_dout_%0d", k),  64'(rsp_dout),  64'd10);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("t5_release_grant", 64'(req_ready), 64'b0010);
    tick();
    check("t5_id_after", 64'(rsp_id),   64'd1);
    check("t5_dout_after", 64'(rsp_dout), 64'd11);
    req_valid = 4'b0001;
    tick();
    check("t5_id_next", 64'(rsp_id),   64'd0);
    check("t5_dout_next", 64'(rsp_dout), 64'd10);
    req_valid = '0;
    tick();
    check("t5_drain", 64'(rsp_valid), 64'd0);

    // 6: reset while FULL with requests pending (pointer is 0, so req1 wins first)
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    tick();
    check("t6_pre_id", 64'(rsp_id), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(rsp_valid), 64'd0);
    check("t6_rst_ready", 64'(req_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("t6_first_grant", 64'(req_ready), 64'b0001);
    tick();
    check("t6_first_id", 64'(rsp_id), 64'd0);

    // Lone requester wins on consecutive cycles
    req_valid = 4'b0100;
    set_din(2, 35'd16);
    #1;
    check("lone_grant_a", 64'(req_ready), 64'b0100);
    tick();
    check("lone_id_a", 64'(rsp_id), 64'd2);
    check("lone_grant_b", 64'(req_ready), 64'b0100);
    tick();
    check("lone_id_b", 64'(rsp_id), 64'd2);
    check("lone_dout", 64'(rsp_dout), 64'd2);
    req_valid = '0;
    tick();
    check("final_drain", 64'(rsp_valid), 64'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
